// File: rtl/rstseq.sv
// Reset sequencer: turns device-table reset requests into stretched system,
// memory and CPU reset domains, a sticky power-off request and a cause record.
module rstseq #(
  parameter int unsigned PORCYCLES = 1024,
  parameter int unsigned RSTCYCLES = 256,
  parameter int unsigned CNTBITSZ  = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rst0_i,
  input  logic       rst1_i,
  input  logic       rst2_i,
  output logic       sysrst_o,
  output logic       memrst_o,
  output logic       cpurst_o,
  output logic       pwroff_o,
  output logic [2:0] cause_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_POR, S_RUN, S_HOLD, S_RHOLD, S_WAIT, S_OFF
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_POR    = 3'd0,
    CAUSE_WRESET = 3'd1,
    CAUSE_CRESET = 3'd2,
    CAUSE_RRESET = 3'd3,
    CAUSE_PWROFF = 3'd4
  } cause_t;

  localparam logic [CNTBITSZ-1:0] POR_LAST = CNTBITSZ'(PORCYCLES - 1);
  localparam logic [CNTBITSZ-1:0] RST_LAST = CNTBITSZ'(RSTCYCLES - 1);

  state_t              state;
  logic [CNTBITSZ-1:0] cnt;

  logic   take_lvl;
  state_t lvl_state;
  cause_t lvl_cause;
  logic   lvl_mem;
  logic   lvl_pwr;

  // Level requests are honoured from RUN and also escalate an RRESET hold.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    take_lvl  = 1'b0;
    lvl_state = S_HOLD;
    lvl_cause = CAUSE_CRESET;
    lvl_mem   = 1'b1;
    lvl_pwr   = 1'b0;
    if ((state == S_RUN || state == S_RHOLD) && (rst0_i || rst1_i)) begin
      take_lvl = 1'b1;
      if (rst1_i && rst0_i) begin
        lvl_state = S_HOLD;
        lvl_cause = CAUSE_CRESET;
      end else if (rst1_i) begin
        lvl_state = S_HOLD;
        lvl_cause = CAUSE_WRESET;
        lvl_mem   = 1'b0;
      end else begin
        lvl_state = S_OFF;
        lvl_cause = CAUSE_PWROFF;
        lvl_pwr   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_POR;
      cnt      <= '0;
      sysrst_o <= 1'b1;
      memrst_o <= 1'b1;
      cpurst_o <= 1'b1;
      pwroff_o <= 1'b0;
      cause_o  <= CAUSE_POR;
      busy_o   <= 1'b1;
    end else if (take_lvl) begin
      state    <= lvl_state;
      cnt      <= '0;
      sysrst_o <= 1'b1;
      memrst_o <= lvl_mem;
      cpurst_o <= 1'b1;
      pwroff_o <= lvl_pwr;
      cause_o  <= lvl_cause;
      busy_o   <= 1'b1;
    end else begin
      case (state)
        S_POR: begin
          if (cnt == POR_LAST) begin
            state    <= S_RUN;
            cnt      <= '0;
            sysrst_o <= 1'b0;
            memrst_o <= 1'b0;
            cpurst_o <= 1'b0;
            busy_o   <= 1'b0;
          end else begin
            cnt <= cnt + CNTBITSZ'(1);
          end
        end
        S_RUN: begin
          if (rst2_i) begin
            state    <= S_RHOLD;
            cnt      <= '0;
            cpurst_o <= 1'b1;
            cause_o  <= CAUSE_RRESET;
            busy_o   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == RST_LAST) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNTBITSZ'(1);
          end
        end
        // Guards against a device table that has not yet dropped its request.
        S_WAIT: begin
          if (!rst0_i && !rst1_i) begin
            state    <= S_RUN;
            cnt      <= '0;
            sysrst_o <= 1'b0;
            memrst_o <= 1'b0;
            cpurst_o <= 1'b0;
            busy_o   <= 1'b0;
          end
        end
        S_RHOLD: begin
          if (cnt == RST_LAST) begin
            state    <= S_RUN;
            cnt      <= '0;
            cpurst_o <= 1'b0;
            busy_o   <= 1'b0;
          end else begin
            cnt <= cnt + CNTBITSZ'(1);
          end
        end
        S_OFF: begin
          state <= S_OFF;
        end
        default: begin
          state <= S_POR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rstseq.sv
// Directed bench for rstseq with PORCYCLES=8, RSTCYCLES=4; expected pulse
// widths and causes are hand-derived from the sequencer's behaviour.
module tb_rstseq;

  localparam int POR_N = 8;
  localparam int RST_N = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rst0_i, rst1_i, rst2_i;
  logic       sysrst_o, memrst_o, cpurst_o, pwroff_o, busy_o;
  logic [2:0] cause_o;

  int n_checks = 0;
  int n_fail   = 0;

  rstseq #(.PORCYCLES(POR_N), .RSTCYCLES(RST_N), .CNTBITSZ(16)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rst0_i   (rst0_i),
    .rst1_i   (rst1_i),
    .rst2_i   (rst2_i),
    .sysrst_o (sysrst_o),
    .memrst_o (memrst_o),
    .cpurst_o (cpurst_o),
    .pwroff_o (pwroff_o),
    .cause_o  (cause_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Call after setting the request inputs; tick 1 is the edge that accepts them.
  // Counts clocks each reset is high until busy_o drops.
  task automatic run_seq(input int clr_after, input int pulse_at,
                         output int n_sys, output int n_mem, output int n_cpu,
                         output logic timed_out);
    n_sys = 0; n_mem = 0; n_cpu = 0; timed_out = 1'b1;
    for (int t = 1; t <= 300; t++) begin
      tick();
      if (t == 1 || t == pulse_at + 1) rst2_i = 1'b0;
      if (t == pulse_at) rst2_i = 1'b1;
      if (t == clr_after) begin rst0_i = 1'b0; rst1_i = 1'b0; end
      if (!busy_o) begin timed_out = 1'b0; break; end
      n_sys += int'(sysrst_o);
      n_mem += int'(memrst_o);
      n_cpu += int'(cpurst_o);
    end
  endtask

  task automatic por_sequence(input string tag);
    for (int k = 1; k < POR_N; k++) begin
      tick();
      check({tag, "_hold"}, {sysrst_o, memrst_o, cpurst_o, busy_o}, 4'b1111);
    end
    tick();
    check({tag, "_done"}, {sysrst_o, memrst_o, cpurst_o, pwroff_o, busy_o}, 5'b00000);
    check({tag, "_cause"}, cause_o, 3'd0);
  endtask

  int   ns, nm, nc, same;
  logic to;

  initial begin
    rst_i = 1'b1; rst0_i = 1'b0; rst1_i = 1'b0; rst2_i = 1'b0;
    #2;
    check("async_rst_out", {sysrst_o, memrst_o, cpurst_o, pwroff_o, busy_o}, 5'b11101);
    check("async_rst_cause", cause_o, 3'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_held", {sysrst_o, memrst_o, cpurst_o, busy_o}, 4'b1111);
    rst_i = 1'b0;
    por_sequence("por");
    repeat (3) tick();
    check("idle_run", {sysrst_o, memrst_o, cpurst_o, busy_o}, 4'b0000);

    // CRESET: device table clears its requests two clocks after sysrst rises.
    rst1_i = 1'b1; rst0_i = 1'b1;
    run_seq(2, 0, ns, nm, nc, to);
    check("creset_timeout", to, 1'b0);
    check("creset_sys", ns, 5);
    check("creset_mem", nm, 5);
    check("creset_cpu", nc, 5);
    check("creset_cause", cause_o, 3'd2);

    // WRESET preserves RAM: memrst_o never rises.
    rst1_i = 1'b1;
    run_seq(2, 0, ns, nm, nc, to);
    check("wreset_timeout", to, 1'b0);
    check("wreset_sys", ns, 5);
    check("wreset_mem", nm, 0);
    check("wreset_cpu", nc, 5);
    check("wreset_cause", cause_o, 3'd1);

    // Request held past the hold window: WAIT stretches until it drops.
    rst1_i = 1'b1;
    run_seq(10, 0, ns, nm, nc, to);
    check("wait_timeout", to, 1'b0);
    check("wait_sys", ns, 10);
    check("wait_mem", nm, 0);

    // RRESET, with a second pulse mid-hold that must not restart the count.
    rst2_i = 1'b1;
    run_seq(0, 0, ns, nm, nc, to);
    check("rreset_timeout", to, 1'b0);
    check("rreset_sys", ns, 0);
    check("rreset_cpu", nc, 4);
    check("rreset_cause", cause_o, 3'd3);
    rst2_i = 1'b1;
    run_seq(0, 2, ns, nm, nc, to);
    check("rreset2_timeout", to, 1'b0);
    check("rreset2_cpu", nc, 4);
    check("rreset2_mem", nm, 0);

    // RRESET and WRESET together: the level request wins.
    rst2_i = 1'b1; rst1_i = 1'b1;
    run_seq(2, 0, ns, nm, nc, to);
    check("prio_timeout", to, 1'b0);
    check("prio_sys", ns, 5);
    check("prio_mem", nm, 0);
    check("prio_cpu", nc, 5);
    check("prio_cause", cause_o, 3'd1);

    // PWROFF from RUN, then stays frozen whatever the inputs do.
    rst0_i = 1'b1;
    tick();
    check("off_out", {sysrst_o, memrst_o, cpurst_o, pwroff_o, busy_o}, 5'b11111);
    check("off_cause", cause_o, 3'd4);
    same = 0;
    for (int k = 0; k < 120; k++) begin
      {rst2_i, rst1_i, rst0_i} = 3'($urandom_range(0, 7));
      tick();
      if ({sysrst_o, memrst_o, cpurst_o, pwroff_o, busy_o, cause_o} == 8'b11111_100) same++;
    end
    check("off_sticky", same, 120);
    rst0_i = 1'b0; rst1_i = 1'b0; rst2_i = 1'b0;

    // Async reset between edges clears pwroff_o before the next clock.
    #2 rst_i = 1'b1;
    #1;
    check("off_async_out", {sysrst_o, memrst_o, cpurst_o, pwroff_o, busy_o}, 5'b11101);
    check("off_async_cause", cause_o, 3'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    por_sequence("por2");

    // PWROFF rising during an RRESET hold escalates to OFF.
    rst2_i = 1'b1;
    tick();
    rst2_i = 1'b0;
    check("esc_rhold_out", {sysrst_o, memrst_o, cpurst_o, pwroff_o}, 4'b0010);
    check("esc_rhold_cause", cause_o, 3'd3);
    rst0_i = 1'b1;
    tick();
    check("esc_off_out", {sysrst_o, memrst_o, cpurst_o, pwroff_o, busy_o}, 5'b11111);
    check("esc_off_cause", cause_o, 3'd4);
    repeat (10) tick();
    check("esc_off_hold", {pwroff_o, cause_o}, 4'b1100);
    rst0_i = 1'b0;

    #2 rst_i = 1'b1;
    #1;
    check("final_async", {pwroff_o, cause_o, sysrst_o}, 5'b0_000_1);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rstseq.md
Name: rstseq

Overview:
- Reset sequencer directly downstream of the device table block. It consumes that block's rst0/rst1 (PWROFF/WRESET/CRESET request levels) and rst2 (RRESET pulse).
- It generates stretched, glitch-free reset domains for the SoC: system, memory and CPU resets, plus a power-off request.
- It records the cause of the last reset so firmware and the bench can read it back.
- Its sysrst_o output drives the synchronous reset of the device table, which clears the request levels that started the sequence.

Parameters:
PORCYCLES   1024  cycles all resets stay asserted after rst_i deasserts (power-on reset); legal range 2..65535
RSTCYCLES   256   cycles resets stay asserted for WRESET/CRESET/RRESET; legal range 2..65535
CNTBITSZ    16    counter width; must hold max(PORCYCLES,RSTCYCLES)

Ports:
clk_i      in   1  clock
rst_i      in   1  reset, asynchronous, active-high
rst0_i     in   1  request level from device table (bit0 of {rst1,rst0})
rst1_i     in   1  request level from device table (bit1)
rst2_i     in   1  RRESET single-cycle pulse from device table
sysrst_o   out  1  system reset to all devices including the device table; active-high
memrst_o   out  1  RAM controller/cache reset; active-high
cpurst_o   out  1  CPU core reset; active-high
pwroff_o   out  1  power-off request to the board; sticky
cause_o    out  3  last reset cause: 0 POR, 1 WRESET, 2 CRESET, 3 RRESET, 4 PWROFF
busy_o     out  1  a sequence is in progress (state != RUN)

Behaviour:
- All outputs are registered and change only on posedge clk_i or on async assertion of rst_i.
- Async reset (rst_i=1), takes effect immediately:
  - state=POR, cnt=0
  - sysrst_o=memrst_o=cpurst_o=1, pwroff_o=0, cause_o=0, busy_o=1
- States: POR, RUN, HOLD, RHOLD, WAIT, OFF.
- POR: cnt increments each clock after rst_i falls. When cnt==PORCYCLES-1, next state is RUN and cnt=0. All resets deassert on the same edge that enters RUN, so they are held exactly PORCYCLES clocks after rst_i release.
- RUN: all resets 0, busy_o=0. Inputs are sampled every cycle; the decision is taken in cycle N and outputs change at edge N+1. Priority order:
  1. rst1_i&rst0_i (CRESET): go to HOLD; sysrst_o=memrst_o=cpurst_o=1; cause_o=2.
  2. rst1_i only (WRESET): go to HOLD; sysrst_o=cpurst_o=1, memrst_o=0 (RAM contents are preserved); cause_o=1.
  3. rst0_i only (PWROFF): go to OFF; sysrst_o=memrst_o=cpurst_o=1, pwroff_o=1; cause_o=4.
  4. rst2_i (RRESET): go to RHOLD; cpurst_o=1 only; cause_o=3.
- HOLD: resets are held exactly RSTCYCLES clocks, then the state goes to WAIT with the resets still asserted. All inputs are ignored.
- WAIT: resets stay asserted until rst0_i==0 && rst1_i==0. On the first cycle both are 0, the next edge enters RUN with all resets 0 and cnt=0. WAIT exists only as a guard against a device table that has not cleared its requests; normally it lasts one cycle.
- RHOLD: cpurst_o is held exactly RSTCYCLES clocks, then the state returns directly to RUN.
  - If rst1_i or rst0_i rises during RHOLD, it escalates at the next edge: the state goes to HOLD or OFF per the RUN priority, cnt restarts at 0, and cause_o is updated.
  - rst2_i pulses during RHOLD are ignored; no restart.
- OFF: terminal state; outputs are frozen; only rst_i leaves it.
- Counter width: cnt compares with ==; it never wraps because the legal parameter range fits CNTBITSZ.
- Simultaneous events:
  - rst2_i together with rst0_i/rst1_i in RUN: rst0_i/rst1_i wins and the RRESET is dropped.
  - rst_i asserted mid-sequence: this is an immediate async reset to POR, and cause_o becomes 0.
- cause_o persists through HOLD/WAIT/RUN and changes only on a new accepted request or on rst_i.
- busy_o=1 in every state except RUN.

Test Plan:
- Power-on: pulse rst_i 3 cycles with PORCYCLES=8 -> all resets 1 during rst_i and for exactly 8 clocks after its release; then 0, busy_o=0, cause_o=0.
- CRESET with RSTCYCLES=4: hold rst1_i=rst0_i=1 in RUN, model the device table by clearing them 2 cycles after sysrst_o rises -> sysrst/memrst/cpurst =1 for 4 clocks plus 1 WAIT clock; cause_o=2.
- WRESET, same setup: rst1_i=1 only -> sysrst_o=cpurst_o=1 for 4(+1) clocks, memrst_o stays 0 throughout, cause_o=1. Repeat while keeping rst1_i high past the hold -> the block stays in WAIT until it drops.
- RRESET: single-cycle rst2_i -> only cpurst_o=1 for exactly 4 clocks; sysrst_o=0; cause_o=3. A second rst2_i pulse mid-hold must not extend the 4-clock count.
- Escalation/priority:
  - rst2_i and rst1_i in the same cycle -> WRESET sequence, cause_o=1.
  - rst0_i rising during RHOLD -> OFF, pwroff_o=1, cause_o=4.
- PWROFF stickiness: rst0_i=1 -> pwroff_o=1 and all resets 1 for 100+ cycles regardless of inputs. An async rst_i asserted mid-cycle clears pwroff_o immediately (before the next clock edge) and restarts POR with cause_o=0.
